countdown_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 13 +
 rtl/countdown_timer.sv | 85 ++++++++
 tb/tb_countdown_timer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types for the loadable countdown timer: state encoding and default width.
package timer_pkg;

  localparam int TIMER_WIDTH = 4;

  // Encoding 2'd3 is unused and treated as IDLE everywhere.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter: valid/ready load, enabled countdown to zero, one-cycle DONE
// pulse at terminal count, optional periodic auto-reload.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             AUTO_RELOAD,
  input  logic             EN,
  input  logic             ABORT,
  output logic [WIDTH-1:0] COUNT,
  output logic             BUSY,
  output logic             PAUSED,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_t     state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             auto_mode;
  logic             done;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= ST_IDLE;
      count     <= '0;
      reload    <= '0;
      auto_mode <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN, ST_PAUSE: begin
          if (ABORT) begin
            count <= '0;
            state <= ST_IDLE;
          end else if (!EN) begin
            state <= ST_PAUSE;
          end else if (count > ONE) begin
            count <= count - ONE;
            state <= ST_RUN;
          end else begin
            // Terminal edge: explicit 1->reload / 1->0 so the decrement never wraps.
            done <= 1'b1;
            if (auto_mode) begin
              count <= reload;
              state <= ST_RUN;
            end else begin
              count <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          // IDLE, and the illegal encoding which is steered back to IDLE.
          state <= ST_IDLE;
          if (LOAD_VALID) begin
            if (LOAD_VALUE != '0) begin
              count     <= LOAD_VALUE;
              reload    <= LOAD_VALUE;
              auto_mode <= AUTO_RELOAD;
              state     <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign BUSY       = (state == ST_RUN) || (state == ST_PAUSE);
  assign PAUSED     = (state == ST_PAUSE);
  assign LOAD_READY = !BUSY;
  assign COUNT      = count;
  assign DONE       = done;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized traffic
// compared against a behavioural model of the timer's rules.
module tb_countdown_timer;

  localparam int W = 4;

  logic         CLK;
  logic         CLR;
  logic         LOAD_VALID;
  logic         LOAD_READY;
  logic [W-1:0] LOAD_VALUE;
  logic         AUTO_RELOAD;
  logic         EN;
  logic         ABORT;
  logic [W-1:0] COUNT;
  logic         BUSY;
  logic         PAUSED;
  logic         DONE;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "active" timer with remaining count, plus a pending done flag.
  bit m_active, m_paused, m_auto, m_done;
  int m_cnt, m_rel;

  countdown_timer #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_VALUE(LOAD_VALUE), .AUTO_RELOAD(AUTO_RELOAD), .EN(EN), .ABORT(ABORT),
    .COUNT(COUNT), .BUSY(BUSY), .PAUSED(PAUSED), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_auto = 0; m_done = 0; m_cnt = 0; m_rel = 0;
  endtask

  task automatic model_edge(input bit lv, input int val, input bit au, input bit en, input bit ab);
    m_done = 0;
    if (m_active) begin
      if (ab) begin
        m_active = 0; m_paused = 0; m_cnt = 0;
      end else if (!en) begin
        m_paused = 1;
      end else begin
        m_paused = 0;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1;
          if (m_auto) m_cnt = m_rel;
          else m_active = 0;
        end
      end
    end else if (lv) begin
      if (val == 0) m_done = 1;
      else begin
        m_active = 1; m_cnt = val; m_rel = val; m_auto = au;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, COUNT, m_cnt);
    check({tag, ".done"}, DONE, m_done);
    check({tag, ".busy"}, BUSY, m_active);
    check({tag, ".paused"}, PAUSED, m_active && m_paused);
    check({tag, ".ready"}, LOAD_READY, !m_active);
  endtask

  // Drive inputs, take one clock edge, update the model, then compare 1 time unit later.
  task automatic step(input string tag, input bit lv, input int val, input bit au,
                      input bit en, input bit ab);
    LOAD_VALID = lv; LOAD_VALUE = val[W-1:0]; AUTO_RELOAD = au; EN = en; ABORT = ab;
    @(posedge CLK);
    model_edge(lv, val, au, en, ab);
    #1;
    check_outputs(tag);
  endtask

  // Runs with EN=1 until DONE is seen; returns the number of edges taken (0 on timeout).
  task automatic run_until_done(input string tag, input int budget, input int pause_at,
                                input int pause_len, output int edges);
    int paused_left;
    paused_left = pause_len;
    edges = 0;
    for (int k = 1; k <= budget; k++) begin
      if (paused_left > 0 && COUNT == pause_at[W-1:0]) begin
        step(tag, 0, 0, 0, 0, 0);
        check({tag, ".pause_hold"}, COUNT, pause_at);
        paused_left--;
      end else begin
        step(tag, 0, 0, 0, 1, 0);
      end
      if (DONE) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int edges, dones, lat;
    LOAD_VALID = 0; LOAD_VALUE = '0; AUTO_RELOAD = 0; EN = 0; ABORT = 0;
    model_reset();
    CLR = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge CLK);
    CLR = 1'b1;
    #1;

    // N=5 one-shot: DONE five edges after accept, then ready again.
    step("load5", 1, 5, 0, 1, 0);
    run_until_done("run5", 20, -1, 0, edges);
    check("lat5", edges, 5);
    check("lat5.ready", LOAD_READY, 1);
    step("after5", 0, 0, 0, 1, 0);

    // N=3 auto-reload: DONE every 3 enabled cycles, COUNT never 0.
    step("load3a", 1, 3, 1, 1, 0);
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      step("auto3", 0, 0, 0, 1, 0);
      if (DONE) dones++;
      if (COUNT == 0) check("auto3.nonzero", COUNT, 1);
    end
    check("auto3.dones", dones, 3);
    step("auto3.abort", 0, 0, 0, 1, 1);

    // N=6 with EN low for 2 cycles at COUNT=4: DONE two cycles later.
    step("load6", 1, 6, 0, 1, 0);
    run_until_done("run6", 20, 4, 2, edges);
    check("lat6", edges, 8);

    // N=4, ABORT on the terminal edge: no DONE.
    step("load4", 1, 4, 0, 1, 0);
    for (int k = 0; k < 3; k++) step("run4", 0, 0, 0, 1, 0);
    check("run4.at1", COUNT, 1);
    step("abort4", 0, 0, 0, 1, 1);
    check("abort4.done", DONE, 0);

    // Load while busy is held off; LOAD_VALID kept high until accepted.
    step("load4b", 1, 4, 0, 1, 0);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      step("hold9", 1, 9, 0, 1, 0);
      if (COUNT == 9) begin lat = k; break; end
    end
    check("hold9.accept_edge", lat, 5);
    step("hold9.abort", 0, 0, 0, 1, 1);

    // N=0: single DONE, never busy.
    step("load0", 1, 0, 0, 1, 0);
    check("load0.done", DONE, 1);
    step("load0.after", 0, 0, 0, 1, 0);
    check("load0.single", DONE, 0);

    // N=15, max value.
    step("load15", 1, 15, 0, 1, 0);
    run_until_done("run15", 30, -1, 0, edges);
    check("lat15", edges, 15);

    // Asynchronous reset mid-count, between edges.
    step("load9", 1, 9, 0, 1, 0);
    step("run9", 0, 0, 0, 1, 0);
    step("run9", 0, 0, 0, 1, 0);
    check("run9.at7", COUNT, 7);
    #2;
    CLR = 1'b0;
    #1;
    model_reset();
    check_outputs("async_clr");
    @(posedge CLK);
    #1;
    check_outputs("clr_held");
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    step("load2", 1, 2, 0, 1, 0);
    run_until_done("run2", 10, -1, 0, edges);
    check("lat2", edges, 2);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
           $urandom_range(0, 1), ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
